ifns_decoder_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 24-bit IFNS crosstalk-avoidance decoder.
- Decodes NUM_CH parallel Fibonacci-numeral-system codewords of CODE_W bits back to DATA_W-bit binary words.
- Uses a valid/ready stream handshake and a 2-stage adder pipeline with back-pressure.
- Sits at the receive end of a CAC-encoded bus, between the bus capture flops and the data consumer.

---
 rtl/ifns_decoder_pipe_pkg.sv | 34 +++
 rtl/ifns_decoder_pipe_group_sum.sv | 23 ++
 rtl/ifns_decoder_pipe.sv | 145 ++++++++++++++
 tb/tb_ifns_decoder_pipe.sv | 521 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifns_decoder_pipe_pkg.sv
// ifns_pkg: Fibonacci weight helpers and shared constants for the IFNS decoder pipeline.
// Used by ifns_decoder_pipe and ifns_group_sum.
package ifns_pkg;

    localparam int ERRCNT_W = 16;

    // Weight of code bit d_k: W[1]=1, W[2]=2, W[k]=W[k-1]+W[k-2]
    function automatic int fib_w(input int k);
        int a;
        int b;
        int t;
        a = 1;
        b = 2;
        if (k <= 1) begin
            b = 1;
        end else begin
            for (int i = 3; i <= k; i++) begin
                t = a + b;
                a = b;
                b = t;
            end
        end
        return b;
    endfunction

    function automatic int data_w(input int code_w);
        return $clog2(fib_w(code_w + 1));
    endfunction

    function automatic int num_groups(input int code_w, input int group_w);
        return (code_w + group_w - 1) / group_w;
    endfunction

endpackage

// File: rtl/ifns_decoder_pipe_group_sum.sv
// ifns_group_sum: combinational Fibonacci-weighted sum of one codeword slice.
// BASE is the 1-based code index of the slice's bit 0.
module ifns_group_sum
    import ifns_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BASE  = 1,
    parameter int SUM_W = 18
) (
    input  logic [WIDTH-1:0] i_bits,
    output logic [SUM_W-1:0] o_sum
);

    always_comb begin
        o_sum = '0;
        for (int j = 0; j < WIDTH; j++) begin
            if (i_bits[j]) begin
                o_sum = o_sum + SUM_W'(fib_w(BASE + j));
            end
        end
    end

endmodule

// File: rtl/ifns_decoder_pipe.sv
// ifns_decoder_pipe: 2-stage pipelined multi-channel IFNS decoder with valid/ready back-pressure.
// Define IFNS_DEC_ERR_CHECK_EN to add per-channel range flags (code_err) and a saturating err_count.
module ifns_decoder_pipe
    import ifns_pkg::*;
#(
    parameter int CODE_W  = 24,
    parameter int NUM_CH  = 1,
    parameter int GROUP_W = 8,
    parameter int DATA_W  = data_w(CODE_W)
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*CODE_W-1:0] codein,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] dataout
`ifdef IFNS_DEC_ERR_CHECK_EN
    ,
    output logic [NUM_CH-1:0]        code_err,
    output logic [ERRCNT_W-1:0]      err_count
`endif
);

    localparam int NUM_G = num_groups(CODE_W, GROUP_W);
    localparam int SUM_W = DATA_W + 1;

    logic [SUM_W-1:0]          w_part  [NUM_CH][NUM_G];
    logic [SUM_W-1:0]          r_part  [NUM_CH][NUM_G];
    logic [SUM_W-1:0]          w_total [NUM_CH];
    logic                      r_v1;
    logic                      r_v2;
    logic [NUM_CH*DATA_W-1:0]  r_data;
    logic                      w_en1;
    logic                      w_en2;
    logic                      w_accept;

    assign w_en2    = ~r_v2 | out_ready;
    assign w_en1    = ~r_v1 | w_en2;
    assign w_accept = in_valid & w_en1;
    assign in_ready = w_en1;

    // The last group of each channel is narrower when GROUP_W does not divide CODE_W
    for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_ch
        for (genvar gg = 0; gg < NUM_G; gg++) begin : g_grp
            localparam int LO  = gg * GROUP_W;
            localparam int WID = ((CODE_W - LO) < GROUP_W) ? (CODE_W - LO) : GROUP_W;
            ifns_group_sum #(
                .WIDTH (WID),
                .BASE  (LO + 1),
                .SUM_W (SUM_W)
            ) u_grp (
                .i_bits (codein[gc*CODE_W + LO +: WID]),
                .o_sum  (w_part[gc][gg])
            );
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int g = 0; g < NUM_G; g++) begin
                    r_part[c][g] <= '0;
                end
            end
        end else if (w_en1) begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_part <= w_part;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_total[c] = '0;
            for (int g = 0; g < NUM_G; g++) begin
                w_total[c] = w_total[c] + r_part[c][g];
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_v2   <= 1'b0;
            r_data <= '0;
        end else if (w_en2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    r_data[c*DATA_W +: DATA_W] <= w_total[c][DATA_W-1:0];
                end
            end
        end
    end

    assign out_valid = r_v2;
    assign dataout   = r_data;

`ifdef IFNS_DEC_ERR_CHECK_EN
    localparam logic [SUM_W-1:0] CODE_LIMIT = SUM_W'(fib_w(CODE_W + 1));

    logic [NUM_CH-1:0]     r_err;
    logic [ERRCNT_W-1:0]   r_errCount;
    logic [ERRCNT_W:0]     w_errSum;

    always_comb begin
        w_errSum = {1'b0, r_errCount};
        for (int c = 0; c < NUM_CH; c++) begin
            w_errSum = w_errSum + {{ERRCNT_W{1'b0}}, r_err[c]};
        end
    end

    // Flags ride with dataout; the counter samples them on each output handshake
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_err      <= '0;
            r_errCount <= '0;
        end else begin
            if (w_en2 && r_v1) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    r_err[c] <= (w_total[c] >= CODE_LIMIT);
                end
            end
            if (r_v2 && out_ready) begin
                r_errCount <= w_errSum[ERRCNT_W] ? {ERRCNT_W{1'b1}} : w_errSum[ERRCNT_W-1:0];
            end
        end
    end

    assign code_err  = r_err;
    assign err_count = r_errCount;
`else
    logic [NUM_CH-1:0] w_unusedTopBits;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_unusedTopBits[c] = w_total[c][DATA_W];
        end
    end
`endif

endmodule

// File: tb/tb_ifns_decoder_pipe.sv
// tb_ifns_decoder_pipe: randomized self-checking bench for ifns_decoder_pipe against a queue-based decode model.
// Error-flag checks are compiled in when IFNS_DEC_ERR_CHECK_EN is defined.
`timescale 1ns/1ps
module tb_ifns_decoder_pipe;

    localparam int CW_A  = 24;
    localparam int NCH_A = 4;
    localparam int DW_A  = 17;
    localparam int CW_B  = 13;
    localparam int NCH_B = 2;
    localparam int GW_B  = 5;
    localparam int DW_B  = 10;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    logic                    inValidA = 1'b0;
    logic                    inReadyA;
    logic [NCH_A*CW_A-1:0]   codeinA  = '0;
    logic                    outValidA;
    logic                    outReadyA = 1'b0;
    logic [NCH_A*DW_A-1:0]   dataoutA;
    logic                    inValidB = 1'b0;
    logic                    inReadyB;
    logic [NCH_B*CW_B-1:0]   codeinB  = '0;
    logic                    outValidB;
    logic                    outReadyB = 1'b0;
    logic [NCH_B*DW_B-1:0]   dataoutB;
`ifdef IFNS_DEC_ERR_CHECK_EN
    logic [NCH_A-1:0]        codeErrA;
    logic [15:0]             errCountA;
    logic [NCH_B-1:0]        codeErrB;
    logic [15:0]             errCountB;
`endif

    ifns_decoder_pipe #(.CODE_W(CW_A), .NUM_CH(NCH_A), .GROUP_W(8)) u_dutA (
        .clock     (clock),
        .rst       (rst),
        .in_valid  (inValidA),
        .in_ready  (inReadyA),
        .codein    (codeinA),
        .out_valid (outValidA),
        .out_ready (outReadyA),
        .dataout   (dataoutA)
`ifdef IFNS_DEC_ERR_CHECK_EN
        ,
        .code_err  (codeErrA),
        .err_count (errCountA)
`endif
    );

    ifns_decoder_pipe #(.CODE_W(CW_B), .NUM_CH(NCH_B), .GROUP_W(GW_B)) u_dutB (
        .clock     (clock),
        .rst       (rst),
        .in_valid  (inValidB),
        .in_ready  (inReadyB),
        .codein    (codeinB),
        .out_valid (outValidB),
        .out_ready (outReadyB),
        .dataout   (dataoutB)
`ifdef IFNS_DEC_ERR_CHECK_EN
        ,
        .code_err  (codeErrB),
        .err_count (errCountB)
`endif
    );

    int assertCount = 0;
    int failCount   = 0;
    int cycleNum    = 0;
    int expErrCount = 0;

    typedef struct {
        logic [NCH_A*DW_A-1:0] data;
        logic [NCH_A-1:0]      err;
        int                    cyc;
    } beatA_t;

    beatA_t sbA[$];

    // Weight of code bit d_k, counted from the Fibonacci recurrence
    function automatic longint weightOf(input int k);
        longint prev = 1;
        longint cur  = 1;
        longint nxt;
        for (int i = 1; i < k; i++) begin
            nxt  = prev + cur;
            prev = cur;
            cur  = nxt;
        end
        return cur;
    endfunction

    function automatic longint refDecode(input logic [63:0] code, input int width);
        longint sum = 0;
        for (int k = 1; k <= width; k++) begin
            if (code[k-1]) sum += weightOf(k);
        end
        return sum;
    endfunction

    function automatic beatA_t modelA(input logic [NCH_A*CW_A-1:0] code);
        beatA_t b;
        longint s;
        b.data = '0;
        b.err  = '0;
        b.cyc  = 0;
        for (int c = 0; c < NCH_A; c++) begin
            s = refDecode(64'(code[c*CW_A +: CW_A]), CW_A);
            b.data[c*DW_A +: DW_A] = s[DW_A-1:0];
            b.err[c] = (s >= weightOf(CW_A + 1));
        end
        return b;
    endfunction

    function automatic logic [NCH_A*CW_A-1:0] randCodeA();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Drive one cycle on DUT A and keep the scoreboard in step with the handshakes
    task automatic cycleA(input logic v, input logic [NCH_A*CW_A-1:0] code, input logic rdy,
                          output logic acc, output logic emit, output logic rdyOut,
                          output logic [NCH_A*DW_A-1:0] data, output logic [NCH_A-1:0] err,
                          output beatA_t exp, output logic expValid, output int emitCyc);
        beatA_t b;
        inValidA  = v;
        codeinA   = code;
        outReadyA = rdy;
        #1;
        rdyOut  = inReadyA;
        acc     = v & inReadyA;
        emit    = outValidA & rdy;
        data    = dataoutA;
`ifdef IFNS_DEC_ERR_CHECK_EN
        err     = codeErrA;
`else
        err     = '0;
`endif
        emitCyc  = cycleNum;
        expValid = 1'b0;
        exp.data = '0;
        exp.err  = '0;
        exp.cyc  = 0;
        if (emit && sbA.size() > 0) begin
            exp      = sbA.pop_front();
            expValid = 1'b1;
            expErrCount += $countones(exp.err);
            if (expErrCount > 65535) expErrCount = 65535;
        end
        if (acc) begin
            b = modelA(code);
            b.cyc = cycleNum;
            sbA.push_back(b);
        end
        @(posedge clock);
        #1;
        cycleNum++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        assertCount++;
        if (outValidA !== 1'b0 || dataoutA !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: out_valid=%b dataout=%h, required 0 and 0", outValidA, dataoutA);
        end
        assertCount++;
        if (outValidB !== 1'b0 || dataoutB !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs_b: out_valid=%b dataout=%h, required 0 and 0", outValidB, dataoutB);
        end
`ifdef IFNS_DEC_ERR_CHECK_EN
        assertCount++;
        if (errCountA !== 16'd0 || codeErrA !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_err: err_count=%0d code_err=%b, required 0", errCountA, codeErrA);
        end
`endif
        rst = 1'b0;
        #1;
        assertCount++;
        if (inReadyA !== 1'b1 || inReadyB !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL reset_ready: in_ready A=%b B=%b, required 1", inReadyA, inReadyB);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_single_codes();
        logic acc, emit, rdyO, expV;
        logic [NCH_A*DW_A-1:0] data;
        logic [NCH_A-1:0] err;
        beatA_t exp;
        int ec;
        int idx = 0;
        logic [NCH_A*CW_A-1:0] codes [3];
        int expCh0 [3] = '{1, 75025, 103682};
        codes[0] = randCodeA(); codes[0][CW_A-1:0] = 24'h000001;
        codes[1] = randCodeA(); codes[1][CW_A-1:0] = 24'h800000;
        codes[2] = randCodeA(); codes[2][CW_A-1:0] = 24'hA00000;
        for (int t = 0; t < 8; t++) begin
            cycleA(t < 3, (t < 3) ? codes[t] : '0, 1'b1, acc, emit, rdyO, data, err, exp, expV, ec);
            if (emit) begin
                assertCount++;
                if (!expV || data !== exp.data || (ec - exp.cyc) != 2) begin
                    failCount++;
                    $display("[TB] FAIL single_model: dataout=%h latency=%0d, required %h latency 2", data, ec - exp.cyc, exp.data);
                end
                if (idx < 3) begin
                    assertCount++;
                    if (data[DW_A-1:0] !== DW_A'(expCh0[idx])) begin
                        failCount++;
                        $display("[TB] FAIL single_ch0_%0d: dataout=%0d, required %0d", idx, data[DW_A-1:0], expCh0[idx]);
                    end
                end
                idx++;
            end
        end
        assertCount++;
        if (idx != 3) begin
            failCount++;
            $display("[TB] FAIL single_count: beats=%0d, required 3", idx);
        end
    endtask

    task automatic test_max_codes();
        logic acc, emit, rdyO, expV;
        logic [NCH_A*DW_A-1:0] data;
        logic [NCH_A-1:0] err;
        beatA_t exp;
        int ec;
        int idx = 0;
        int expVal [2] = '{121392, 65344};
        logic [NCH_A*CW_A-1:0] codes [2];
        codes[0] = '0; codes[0][CW_A-1:0] = 24'hAAAAAA;
        codes[1] = '0; codes[1][CW_A-1:0] = 24'hFFFFFF;
        for (int t = 0; t < 6; t++) begin
            cycleA(t < 2, (t < 2) ? codes[t] : '0, 1'b1, acc, emit, rdyO, data, err, exp, expV, ec);
            if (emit && idx < 2) begin
                assertCount++;
                if (!expV || data[DW_A-1:0] !== DW_A'(expVal[idx])) begin
                    failCount++;
                    $display("[TB] FAIL max_code_%0d: dataout=%0d, required %0d", idx, data[DW_A-1:0], expVal[idx]);
                end
`ifdef IFNS_DEC_ERR_CHECK_EN
                assertCount++;
                if (err[0] !== (idx == 1)) begin
                    failCount++;
                    $display("[TB] FAIL max_code_err_%0d: code_err=%b, required %b", idx, err[0], idx == 1);
                end
`endif
                idx++;
            end
        end
`ifdef IFNS_DEC_ERR_CHECK_EN
        assertCount++;
        if (errCountA !== 16'(expErrCount)) begin
            failCount++;
            $display("[TB] FAIL max_err_count: err_count=%0d, required %0d", errCountA, expErrCount);
        end
`endif
    endtask

    task automatic test_multi_channel();
        logic acc, emit, rdyO, expV;
        logic [NCH_A*DW_A-1:0] data;
        logic [NCH_A-1:0] err;
        beatA_t exp;
        int ec;
        int seen = 0;
        int expCh [NCH_A] = '{1, 2, 75025, 0};
        logic [NCH_A*CW_A-1:0] code;
        code = {24'h000000, 24'h800000, 24'h000002, 24'h000001};
        for (int t = 0; t < 5; t++) begin
            cycleA(t == 0, (t == 0) ? code : '0, 1'b1, acc, emit, rdyO, data, err, exp, expV, ec);
            if (emit) begin
                seen++;
                for (int c = 0; c < NCH_A; c++) begin
                    assertCount++;
                    if (data[c*DW_A +: DW_A] !== DW_A'(expCh[c])) begin
                        failCount++;
                        $display("[TB] FAIL multi_ch%0d: dataout=%0d, required %0d", c, data[c*DW_A +: DW_A], expCh[c]);
                    end
                end
            end
        end
        assertCount++;
        if (seen != 1) begin
            failCount++;
            $display("[TB] FAIL multi_count: beats=%0d, required 1", seen);
        end
    endtask

    task automatic test_back_pressure();
        logic acc, emit, rdyO, expV;
        logic [NCH_A*DW_A-1:0] data;
        logic [NCH_A*DW_A-1:0] held;
        logic [NCH_A-1:0] err;
        beatA_t exp;
        int ec;
        int sent = 0;
        int got = 0;
        logic [NCH_A*CW_A-1:0] code;
        held = '0;
        for (int t = 0; t < 40 && got < 6; t++) begin
            code = randCodeA();
            cycleA(sent < 6, code, t >= 5, acc, emit, rdyO, data, err, exp, expV, ec);
            if (acc) sent++;
            if (t == 2) held = data;
            if (t >= 2 && t < 5) begin
                assertCount++;
                if (rdyO !== 1'b0 || data !== held || sent != 2) begin
                    failCount++;
                    $display("[TB] FAIL bp_hold_%0d: in_ready=%b accepted=%0d dataout=%h, required 0, 2, %h", t, rdyO, sent, data, held);
                end
            end
            if (emit) begin
                got++;
                assertCount++;
                if (!expV || data !== exp.data) begin
                    failCount++;
                    $display("[TB] FAIL bp_order_%0d: dataout=%h, required %h", got, data, exp.data);
                end
            end
        end
        assertCount++;
        if (got != 6 || sbA.size() != 0) begin
            failCount++;
            $display("[TB] FAIL bp_count: beats out=%0d left=%0d, required 6 and 0", got, sbA.size());
        end
    endtask

    task automatic test_random();
        logic acc, emit, rdyO, expV;
        logic [NCH_A*DW_A-1:0] data;
        logic [NCH_A-1:0] err;
        beatA_t exp;
        int ec;
        for (int t = 0; t < 320; t++) begin
            cycleA((t < 300) && ($urandom_range(0, 9) < 7), randCodeA(),
                   (t >= 300) || ($urandom_range(0, 9) < 7), acc, emit, rdyO, data, err, exp, expV, ec);
            if (emit) begin
                assertCount++;
                if (!expV || data !== exp.data) begin
                    failCount++;
                    $display("[TB] FAIL random_data: dataout=%h, required %h", data, exp.data);
                end
`ifdef IFNS_DEC_ERR_CHECK_EN
                assertCount++;
                if (err !== exp.err) begin
                    failCount++;
                    $display("[TB] FAIL random_err: code_err=%b, required %b", err, exp.err);
                end
`endif
            end
        end
        assertCount++;
        if (sbA.size() != 0) begin
            failCount++;
            $display("[TB] FAIL random_drain: %0d beats left, required 0", sbA.size());
        end
`ifdef IFNS_DEC_ERR_CHECK_EN
        assertCount++;
        if (errCountA !== 16'(expErrCount)) begin
            failCount++;
            $display("[TB] FAIL random_err_count: err_count=%0d, required %0d", errCountA, expErrCount);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic acc, emit, rdyO, expV;
        logic [NCH_A*DW_A-1:0] data;
        logic [NCH_A-1:0] err;
        beatA_t exp;
        int ec;
        int got = 0;
        logic [NCH_A*CW_A-1:0] code;
        for (int t = 0; t < 2; t++) begin
            code = randCodeA();
            code[0] = 1'b1;
            cycleA(1'b1, code, 1'b1, acc, emit, rdyO, data, err, exp, expV, ec);
        end
        inValidA = 1'b0;
        rst = 1'b1;
        #1;
        assertCount++;
        if (outValidA !== 1'b0 || dataoutA !== '0) begin
            failCount++;
            $display("[TB] FAIL midreset_clear: out_valid=%b dataout=%h, required 0 and 0", outValidA, dataoutA);
        end
        sbA.delete();
        expErrCount = 0;
        @(posedge clock);
        #1;
        rst = 1'b0;
        #1;
`ifdef IFNS_DEC_ERR_CHECK_EN
        assertCount++;
        if (errCountA !== 16'd0) begin
            failCount++;
            $display("[TB] FAIL midreset_err_count: err_count=%0d, required 0", errCountA);
        end
`endif
        code = randCodeA();
        for (int t = 0; t < 8; t++) begin
            cycleA(t == 1, code, 1'b1, acc, emit, rdyO, data, err, exp, expV, ec);
            if (emit) begin
                got++;
                assertCount++;
                if (!expV || data !== modelA(code).data) begin
                    failCount++;
                    $display("[TB] FAIL midreset_first: dataout=%h, required %h", data, modelA(code).data);
                end
            end
        end
        assertCount++;
        if (got != 1) begin
            failCount++;
            $display("[TB] FAIL midreset_count: beats=%0d, required 1", got);
        end
    endtask

    task automatic test_narrow_group();
        logic [NCH_B*DW_B-1:0] expQ [$];
        logic [NCH_B-1:0]      errQ [$];
        logic [NCH_B*DW_B-1:0] e;
        logic [NCH_B-1:0]      ee;
        logic [31:0]           r;
        longint                s;
        int                    got = 0;
        outReadyB = 1'b1;
        for (int t = 0; t < 46; t++) begin
            r = $urandom;
            inValidB = (t < 40);
            codeinB  = r[NCH_B*CW_B-1:0];
            #1;
            if (outValidB) begin
                got++;
                assertCount++;
                if (expQ.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL narrow_extra: dataout=%h, required no beat", dataoutB);
                end else begin
                    e  = expQ.pop_front();
                    ee = errQ.pop_front();
                    if (dataoutB !== e) begin
                        failCount++;
                        $display("[TB] FAIL narrow_data: dataout=%h, required %h", dataoutB, e);
                    end
`ifdef IFNS_DEC_ERR_CHECK_EN
                    assertCount++;
                    if (codeErrB !== ee) begin
                        failCount++;
                        $display("[TB] FAIL narrow_err: code_err=%b, required %b", codeErrB, ee);
                    end
`endif
                end
            end
            if (inValidB && inReadyB) begin
                for (int c = 0; c < NCH_B; c++) begin
                    s = refDecode(64'(codeinB[c*CW_B +: CW_B]), CW_B);
                    e[c*DW_B +: DW_B] = s[DW_B-1:0];
                    ee[c] = (s >= weightOf(CW_B + 1));
                end
                expQ.push_back(e);
                errQ.push_back(ee);
            end
            @(posedge clock);
            #1;
        end
        inValidB = 1'b0;
        assertCount++;
        if (got != 40) begin
            failCount++;
            $display("[TB] FAIL narrow_count: beats=%0d, required 40", got);
        end
    endtask

`ifdef IFNS_DEC_ERR_CHECK_EN
    task automatic test_saturation();
        logic acc, emit, rdyO, expV;
        logic [NCH_A*DW_A-1:0] data;
        logic [NCH_A-1:0] err;
        beatA_t exp;
        int ec;
        int extra = 0;
        for (int t = 0; t < 20000 && extra < 30; t++) begin
            cycleA(extra < 20, {NCH_A*CW_A{1'b1}}, 1'b1, acc, emit, rdyO, data, err, exp, expV, ec);
            if (expErrCount >= 65535) extra++;
        end
        assertCount++;
        if (errCountA !== 16'hFFFF || expErrCount != 65535) begin
            failCount++;
            $display("[TB] FAIL saturation: err_count=%h model=%0d, required FFFF", errCountA, expErrCount);
        end
    endtask
`endif

    initial begin
        $display("[TB] ifns_decoder_pipe bench starting");
        test_reset();
        test_single_codes();
        test_max_codes();
        test_multi_channel();
        test_back_pressure();
        test_random();
        test_reset_mid();
        test_narrow_group();
`ifdef IFNS_DEC_ERR_CHECK_EN
        test_saturation();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
